// File: rtl/hex_marquee_pkg.sv
// hex_marquee_pkg
// Shared definitions for the hex_marquee scrolling display driver:
//   CHAR_W          width of one character code
//   CH_*            named character codes
//   S_HOLD / S_RUN  scroll FSM state encodings, state_t their type
//   SEG_OFF         active-low pattern with every segment dark
package hex_marquee_pkg;

    localparam int CHAR_W = 3;

    // Codes 3 and 7 both render blank; CH_BLANK names the one used for reset.
    localparam logic [CHAR_W-1:0] CH_D     = 3'd0;
    localparam logic [CHAR_W-1:0] CH_E     = 3'd1;
    localparam logic [CHAR_W-1:0] CH_1     = 3'd2;
    localparam logic [CHAR_W-1:0] CH_BLANK = 3'd3;
    localparam logic [CHAR_W-1:0] CH_S     = 3'd4;
    localparam logic [CHAR_W-1:0] CH_O     = 3'd5;
    localparam logic [CHAR_W-1:0] CH_C     = 3'd6;

    typedef logic [0:0] state_t;
    localparam state_t S_HOLD = 1'b0;
    localparam state_t S_RUN  = 1'b1;

    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/char_to_seg7.sv
// char_to_seg7
// Combinational 3-bit character code to 7-segment decoder.
// Ports:
//   code  in   CHAR_W  character code (see hex_marquee_pkg)
//   seg   out  7       active-low segments, bit 0 = a ... bit 6 = g
module char_to_seg7
    import hex_marquee_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [6:0]        seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            CH_D:    seg = 7'h21;   // b c d e g
            CH_E:    seg = 7'h06;   // a d e f g
            CH_1:    seg = 7'h79;   // b c
            CH_S:    seg = 7'h12;   // a c d f g
            CH_O:    seg = 7'h23;   // c d e g
            CH_C:    seg = 7'h46;   // a d e f
            default: seg = SEG_OFF; // both blank codes
        endcase
    end

endmodule

// File: rtl/hex_marquee.sv
// hex_marquee
// Scrolling-message driver for seven-segment displays. A presettable ring
// of NUM_CHARS character codes is shown through a NUM_HEX-wide window that
// rotates one position every TICK_DIV clocks while running.
// Ports:
//   CLOCK_50  in   1             system clock
//   RESET_N   in   1             asynchronous active-low reset
//   LOAD      in   1             level-sampled preset strobe
//   PRESET    in   NUM_CHARS*3   buffer image, char i = PRESET[3i+2:3i]
//   RUN       in   1             1 = auto-scroll, 0 = hold
//   DIR       in   1             0 = offset increments, 1 = decrements
//   STEP_N    in   1             manual step key, active low (only when
//                                HEX_MARQUEE_STEP_EN is defined)
//   HEX       out  NUM_HEX*7     registered active-low segments per display
//   OFFSET    out  clog2(NUM_CHARS)  current rotation offset
//   TICK      out  1             one-cycle pulse per auto-scroll step
// Build option: define HEX_MARQUEE_STEP_EN to add the STEP_N key, which
// steps the offset once per press while holding.
module hex_marquee
    import hex_marquee_pkg::*;
#(
    parameter  int NUM_CHARS = 8,
    parameter  int NUM_HEX   = 4,
    parameter  int TICK_DIV  = 25_000_000,
    localparam int OFF_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET_N,
    input  logic                        LOAD,
    input  logic [NUM_CHARS*CHAR_W-1:0] PRESET,
    input  logic                        RUN,
    input  logic                        DIR,
`ifdef HEX_MARQUEE_STEP_EN
    input  logic                        STEP_N,
`endif
    output logic [NUM_HEX*7-1:0]        HEX,
    output logic [OFF_W-1:0]            OFFSET,
    output logic                        TICK
);

    localparam int               PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(TICK_DIV - 1);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(NUM_CHARS - 1);

    state_t               state_reg, state_next;
    logic [PS_W-1:0]      presc_reg, presc_next;
    logic [OFF_W-1:0]     offset_reg, offset_next;
    logic                 tick_reg, tick_next;
    logic [NUM_HEX*7-1:0] hex_reg, hex_next;
    logic [CHAR_W-1:0]    chars_reg [NUM_CHARS];
    logic                 wrap;
    logic                 press;

    // ------------------------------------------------------------------
    // Manual step key: two-flop synchroniser, then a falling-edge detect.
    // A press only counts while holding; running ignores it.
    // ------------------------------------------------------------------
`ifdef HEX_MARQUEE_STEP_EN
    logic sync1_reg, sync2_reg, prev_reg;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= STEP_N;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign press = prev_reg & ~sync2_reg & (state_reg == S_HOLD);
`else
    assign press = 1'b0;
`endif

    // The prescaler advances only while the FSM is already in RUN, so the
    // first step lands TICK_DIV cycles after the state changes.
    assign wrap = (state_reg == S_RUN) && (presc_reg == PS_MAX);

    always_comb begin
        state_next  = RUN ? S_RUN : S_HOLD;
        presc_next  = presc_reg;
        offset_next = offset_reg;
        tick_next   = 1'b0;

        if (state_reg == S_RUN)
            presc_next = wrap ? '0 : presc_reg + PS_W'(1);

        // LOAD wins over a coincident tick or key press; both are dropped.
        if (LOAD) begin
            presc_next  = '0;
            offset_next = '0;
        end else if (wrap || press) begin
            tick_next = wrap;
            if (DIR)
                offset_next = (offset_reg == '0) ? OFF_MAX : offset_reg - OFF_W'(1);
            else
                offset_next = (offset_reg == OFF_MAX) ? '0 : offset_reg + OFF_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Character ring: every entry is read in parallel by the display
    // window, so each one is its own register.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_chars
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N)
                chars_reg[gi] <= CH_BLANK;
            else if (LOAD)
                chars_reg[gi] <= PRESET[gi*CHAR_W +: CHAR_W];
        end
    end

    // ------------------------------------------------------------------
    // Display window: display k shows char (k - offset) mod NUM_CHARS.
    // The modulo is an explicit compare so any NUM_CHARS works; one extra
    // bit keeps k + NUM_CHARS - offset from overflowing.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex
        localparam logic [OFF_W:0] K_IDX = (OFF_W + 1)'(gi);
        localparam logic [OFF_W:0] N_IDX = (OFF_W + 1)'(NUM_CHARS);

        logic [OFF_W:0]    off_ext;
        logic [OFF_W:0]    idx;
        logic [CHAR_W-1:0] code;
        logic [6:0]        seg;

        always_comb begin
            off_ext = {1'b0, offset_reg};
            idx     = (K_IDX >= off_ext) ? (K_IDX - off_ext)
                                         : (K_IDX + N_IDX - off_ext);
            code    = chars_reg[idx[OFF_W-1:0]];
        end

        char_to_seg7 u_dec (
            .code (code),
            .seg  (seg)
        );

        assign hex_next[gi*7 +: 7] = seg;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg  <= S_HOLD;
            presc_reg  <= '0;
            offset_reg <= '0;
            tick_reg   <= 1'b0;
            hex_reg    <= {NUM_HEX{SEG_OFF}};
        end else begin
            state_reg  <= state_next;
            presc_reg  <= presc_next;
            offset_reg <= offset_next;
            tick_reg   <= tick_next;
            hex_reg    <= hex_next;
        end
    end

    assign HEX    = hex_reg;
    assign OFFSET = offset_reg;
    assign TICK   = tick_reg;

endmodule
